clk_freq_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous square-wave input against the reference clock `clk_in`. It is the receiving end of the team's clock-divider outputs and of any external divided clock: given a signal whose frequency is unknown, it reports how many reference cycles one period and one high phase last. Used in bring-up to confirm divider settings and in the field as a clock-presence and stall monitor.

---
 rtl/clk_freq_meter.sv | 135 +++++++++++++
 tb/tb_clk_freq_meter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - period / high-time meter for a slow asynchronous square wave
module clk_freq_meter #(
    parameter int unsigned     NBITS     = 32,
    parameter longint unsigned MAX_COUNT = 1_000_000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [NBITS-1:0] period,
    output logic [NBITS-1:0] high_time,
    output logic             valid,
    output logic             stalled
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    localparam logic [NBITS-1:0] CNT_MAX = NBITS'(MAX_COUNT);
    localparam logic [NBITS-1:0] CNT_ONE = NBITS'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             hist_q;
    logic             rise;
    logic             fall;

    logic [1:0]       state_q,   state_d;
    logic [NBITS-1:0] cnt_q,     cnt_d;
    logic [NBITS-1:0] hi_cap_q,  hi_cap_d;
    logic [NBITS-1:0] period_q,  period_d;
    logic [NBITS-1:0] high_q,    high_d;
    logic             valid_q,   valid_d;
    logic             stalled_q, stalled_d;

    // Two-flop synchronizer plus a history flop; free-running so edge
    // detection never depends on enable or FSM state.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~hist_q;
    assign fall = ~sync2_q & hist_q;

    // Next-state logic: enable low overrides everything, a rise beats the
    // stall limit when both land in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hi_cap_q;
                        valid_d   = 1'b1;
                        cnt_d     = CNT_ONE;
                        stalled_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        stalled_d = 1'b1;
                        period_d  = '0;
                        high_d    = '0;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) begin
                            hi_cap_d = cnt_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Measurement state and registered outputs.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_q;
    assign valid     = valid_q;
    assign stalled   = stalled_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - scoreboard bench for clk_freq_meter
module tb_clk_freq_meter;

    localparam int MAX_A = 1000;
    localparam int MAX_B = 20;

    typedef struct {
        int p;
        int h;
    } exp_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        enable  = 1'b0;
    logic        sig_in  = 1'b0;
    logic [31:0] period_a, high_a, period_b, high_b;
    logic        valid_a, stalled_a, valid_b, stalled_b;

    int   n_cmp     = 0;
    int   n_err     = 0;
    int   cyc       = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    bit   have_prev = 1'b0;
    int   r_mark    = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_a;
    exp_t mon_b;

    clk_freq_meter #(.NBITS(32), .MAX_COUNT(MAX_A)) dut_a (
        .clk_in    (clk),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period_a),
        .high_time (high_a),
        .valid     (valid_a),
        .stalled   (stalled_a)
    );

    clk_freq_meter #(.NBITS(32), .MAX_COUNT(MAX_B)) dut_b (
        .clk_in    (clk),
        .reset     (reset),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period_b),
        .high_time (high_b),
        .valid     (valid_b),
        .stalled   (stalled_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives sig_in and pushes the result each rise must produce.
    task automatic drive_sig(input logic v);
        exp_t e;
        if (v && !sig_in) begin
            if (have_prev) begin
                e.p = cyc - last_rise;
                e.h = last_fall - last_rise;
                if (e.p <= MAX_A) q_a.push_back(e);
                if (e.p <= MAX_B) q_b.push_back(e);
            end
            have_prev = 1'b1;
            last_rise = cyc;
        end else if (!v && sig_in) begin
            last_fall = cyc;
        end
        sig_in = v;
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive_sig(1'b1);
            repeat (h) tick();
            drive_sig(1'b0);
            repeat (l) tick();
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset) begin
            if (valid_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_valid", {31'b0, valid_a}, 32'd0);
                end else begin
                    mon_a = q_a.pop_front();
                    check("a_period", period_a, 32'(mon_a.p));
                    check("a_high_time", high_a, 32'(mon_a.h));
                    check("a_stalled_at_valid", {31'b0, stalled_a}, 32'd0);
                end
            end
            if (valid_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_valid", {31'b0, valid_b}, 32'd0);
                end else begin
                    mon_b = q_b.pop_front();
                    check("b_period", period_b, 32'(mon_b.p));
                    check("b_high_time", high_b, 32'(mon_b.h));
                    check("b_stalled_at_valid", {31'b0, stalled_b}, 32'd0);
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_a_period", period_a, 32'd0);
        check("rst_a_high", high_a, 32'd0);
        check("rst_a_valid", {31'b0, valid_a}, 32'd0);
        check("rst_a_stalled", {31'b0, stalled_a}, 32'd0);
        check("rst_b_period", period_b, 32'd0);
        check("rst_b_stalled", {31'b0, stalled_b}, 32'd0);
        reset = 1'b1;
        tick();
        enable = 1'b1;
        repeat (3) tick();

        // divider loopback, 50% duty, period 8
        wave(4, 4, 6);

        // asymmetric duty, 3 high / 7 low
        wave(3, 7, 5);

        // reset mid-measurement with cnt around 100
        drive_sig(1'b1);
        repeat (50) tick();
        drive_sig(1'b0);
        repeat (50) tick();
        check("pre_rst_a_period", period_a, 32'd10);
        check("pre_rst_b_stalled", {31'b0, stalled_b}, 32'd1);
        #2;
        reset     = 1'b0;
        have_prev = 1'b0;
        #1;
        check("async_rst_a_period", period_a, 32'd0);
        check("async_rst_a_high", high_a, 32'd0);
        check("async_rst_a_valid", {31'b0, valid_a}, 32'd0);
        check("async_rst_b_stalled", {31'b0, stalled_b}, 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        wave(3, 7, 4);

        // stall on the MAX_COUNT=20 instance
        wave(5, 5, 3);
        r_mark = last_rise;
        while (cyc < r_mark + 22) tick();
        check("stall_b_not_yet", {31'b0, stalled_b}, 32'd0);
        tick();
        check("stall_b_set", {31'b0, stalled_b}, 32'd1);
        check("stall_b_period", period_b, 32'd0);
        check("stall_b_high", high_b, 32'd0);
        check("stall_a_clear", {31'b0, stalled_a}, 32'd0);
        repeat (5) tick();
        drive_sig(1'b1);
        repeat (5) tick();
        check("stall_b_held_after_arm", {31'b0, stalled_b}, 32'd1);
        drive_sig(1'b0);
        repeat (5) tick();
        wave(5, 5, 3);
        check("stall_b_cleared", {31'b0, stalled_b}, 32'd0);

        // boundary: period exactly MAX_COUNT
        wave(10, 10, 4);
        check("bound_b_stalled", {31'b0, stalled_b}, 32'd0);
        check("bound_b_period", period_b, 32'd20);

        // enable drop mid-period
        wave(6, 6, 3);
        drive_sig(1'b1);
        repeat (4) tick();
        enable    = 1'b0;
        have_prev = 1'b0;
        repeat (5) tick();
        check("endrop_a_period", period_a, 32'd12);
        check("endrop_a_high", high_a, 32'd6);
        check("endrop_b_period", period_b, 32'd12);
        check("endrop_b_high", high_b, 32'd6);
        check("endrop_b_stalled", {31'b0, stalled_b}, 32'd0);
        check("endrop_b_valid", {31'b0, valid_b}, 32'd0);
        enable = 1'b1;
        repeat (2) tick();
        drive_sig(1'b0);
        repeat (6) tick();
        wave(6, 6, 3);

        repeat (5) tick();
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
